bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the SoC memory/peripheral bus.
- Master 0 is the processor core data/fetch port; master 1 is the UART debug loader / DMA-style requester.
- Round-robin grant, one outstanding transaction at a time, optional slave timeout with error response.
- Sits between the requesters and the memory/peripheral decoder inside the SoC top.

Parameters:
- ADDR_WIDTH, 32, address width of masters and slave.
- DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 255, max cycles in a grant state without s_ack before forced error completion; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- m0_req  input  1  master 0 request; level, held until m0_ack.
- m0_we  input  1  master 0 write enable (1 = write, 0 = read).
- m0_addr  input  ADDR_WIDTH  master 0 address.
- m0_wdata  input  DATA_WIDTH  master 0 write data.
- m0_rdata  output  DATA_WIDTH  master 0 read data; valid with m0_ack.
- m0_ack  output  1  master 0 completion pulse.
- m0_err  output  1  master 0 timeout error; valid with m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err  same directions, widths and meaning for master 1.
- s_req  output  1  slave request.
- s_we  output  1  slave write enable.
- s_addr  output  ADDR_WIDTH  slave address.
- s_wdata  output  DATA_WIDTH  slave write data.
- s_rdata  input  DATA_WIDTH  slave read data; valid with s_ack.
- s_ack  input  1  slave completion, one cycle.
- grant  output  2  one-hot current owner; 00 when idle.
- busy  output  1  1 whenever state is not IDLE.

Behaviour:
- States: IDLE, GNT0, GNT1. State, last-owner flag and timeout counter are registered.
- Reset (asynchronous): state = IDLE, last = 1 (m0 wins the first tie), counter = 0.
  - All outputs 0: s_req, s_we, s_addr, s_wdata, m*_ack, m*_err, m*_rdata, grant, busy.
- IDLE:
  - No requests: stay in IDLE.
  - Only m0_req: next state GNT0.
  - Only m1_req: next state GNT1.
  - Both: grant the master that is not `last`.
  - Arbitration latency is 1 cycle: the slave sees s_req no earlier than the cycle after req rises.
- GNTn:
  - s_req = 1; s_we, s_addr, s_wdata muxed combinationally from master n; grant[n] = 1.
  - Counter increments every cycle spent in GNTn.
- Completion:
  - When s_ack = 1 in GNTn: mn_ack = 1 and mn_rdata = s_rdata in the same cycle (combinational path), mn_err = 0.
  - Next edge: state = IDLE, last = n, counter = 0.
- Timeout (TIMEOUT_CYCLES > 0):
  - When counter == TIMEOUT_CYCLES-1 and s_ack = 0: mn_ack = 1, mn_err = 1, mn_rdata = 0.
  - Next edge: state = IDLE, last = n, counter = 0.
  - s_ack and timeout in the same cycle: s_ack wins, err = 0.
- Non-granted master: ack, err and rdata held at 0; the master is never acknowledged for another master's transaction.
- Masters must deassert req, or present a new request, the cycle after ack.
  - Because completion always returns to IDLE, minimum spacing is 2 cycles per transaction and the other master always gets a turn when both are waiting.
- m_req dropping mid-grant is a protocol violation: the arbiter keeps the grant until s_ack or timeout and still pulses that master's ack.
- s_ack received while in IDLE is ignored; no ack is sent to any master.
- Counter width is ceil(log2(TIMEOUT_CYCLES+1)) bits, minimum 1; it never wraps because timeout forces IDLE first.
- Reset asserted mid-transaction returns immediately to IDLE with outputs 0; the in-flight transaction is dropped without ack.

Test Plan:
1. Single read: after reset, m0_req=1, m0_we=0, addr 0x100. Slave acks 2 cycles after s_req with s_rdata=0xCAFEF00D → s_req rises 1 cycle after m0_req; m0_ack=1 and m0_rdata=0xCAFEF00D in the s_ack cycle; grant=00 the next cycle.
2. Tie after reset: m0 and m1 request the same cycle, slave acks immediately, both keep requesting → grant order 01, 10, 01, 10; each ack goes only to the granted master.
3. Write routing: m1 writes 0x12345678 to 0x2000 while m0 is idle → s_we=1, s_addr=0x2000, s_wdata=0x12345678 while grant=10; m0_ack stays 0.
4. Timeout: TIMEOUT_CYCLES=4, m0 reads, slave never acks → m0_ack=1, m0_err=1, m0_rdata=0 on the 4th cycle of GNT0; busy=0 the next cycle. Repeat with s_ack on that same cycle → err=0.
5. Mid-operation reset: assert reset during GNT1 → grant=00, s_req=0 immediately with no clock edge needed; no m1_ack. After release, a tie grants m0 first.
6. Stray s_ack while IDLE → no m*_ack; state stays IDLE.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two requesters, the slave and the arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface bus_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  m0_req;
   logic                  m0_we;
   logic [ADDR_WIDTH-1:0] m0_addr;
   logic [DATA_WIDTH-1:0] m0_wdata;
   logic [DATA_WIDTH-1:0] m0_rdata;
   logic                  m0_ack;
   logic                  m0_err;

   logic                  m1_req;
   logic                  m1_we;
   logic [ADDR_WIDTH-1:0] m1_addr;
   logic [DATA_WIDTH-1:0] m1_wdata;
   logic [DATA_WIDTH-1:0] m1_rdata;
   logic                  m1_ack;
   logic                  m1_err;

   logic                  s_req;
   logic                  s_we;
   logic [ADDR_WIDTH-1:0] s_addr;
   logic [DATA_WIDTH-1:0] s_wdata;
   logic [DATA_WIDTH-1:0] s_rdata;
   logic                  s_ack;

   logic [1:0]            grant;
   logic                  busy;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  s_rdata, s_ack,
      output m0_rdata, m0_ack, m0_err,
      output m1_rdata, m1_ack, m1_err,
      output s_req, s_we, s_addr, s_wdata,
      output grant, busy
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output s_rdata, s_ack,
      input  m0_rdata, m0_ack, m0_err,
      input  m1_rdata, m1_ack, m1_err,
      input  s_req, s_we, s_addr, s_wdata,
      input  grant, busy
   );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter, one outstanding transaction, with an
// optional slave timeout that completes the transaction with an error.
module bus_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   bus_arbiter_if.slave      bus
);

   localparam int CW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam bit TO_EN     = (TIMEOUT_CYCLES > 0);
   localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic                  done_s;
   logic                  err_s;
   logic [DATA_WIDTH-1:0] rdata_s;
   logic                  timeout_hit_s;

   // State, last-owner flag and timeout counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= {CW{1'b0}};
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state arbitration, slave mux and completion routing.
   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      cnt_d         = cnt_q;
      done_s        = 1'b0;
      err_s         = 1'b0;
      rdata_s       = {DATA_WIDTH{1'b0}};
      timeout_hit_s = TO_EN && (cnt_q == TO_LAST);

      bus.s_req     = 1'b0;
      bus.s_we      = 1'b0;
      bus.s_addr    = {ADDR_WIDTH{1'b0}};
      bus.s_wdata   = {DATA_WIDTH{1'b0}};
      bus.m0_ack    = 1'b0;
      bus.m0_err    = 1'b0;
      bus.m0_rdata  = {DATA_WIDTH{1'b0}};
      bus.m1_ack    = 1'b0;
      bus.m1_err    = 1'b0;
      bus.m1_rdata  = {DATA_WIDTH{1'b0}};
      bus.grant     = 2'b00;
      bus.busy      = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            cnt_d = {CW{1'b0}};
            // On a tie, the master that did not own the bus last goes first.
            if (bus.m0_req && bus.m1_req) begin
               state_d = last_q ? GNT0 : GNT1;
            end else if (bus.m0_req) begin
               state_d = GNT0;
            end else if (bus.m1_req) begin
               state_d = GNT1;
            end else begin
               state_d = IDLE;
            end
         end
         GNT0, GNT1: begin
            bus.s_req = 1'b1;
            if (state_q == GNT0) begin
               bus.s_we    = bus.m0_we;
               bus.s_addr  = bus.m0_addr;
               bus.s_wdata = bus.m0_wdata;
               bus.grant   = 2'b01;
            end else begin
               bus.s_we    = bus.m1_we;
               bus.s_addr  = bus.m1_addr;
               bus.s_wdata = bus.m1_wdata;
               bus.grant   = 2'b10;
            end

            // A real slave ack beats a timeout landing in the same cycle.
            if (bus.s_ack) begin
               done_s  = 1'b1;
               err_s   = 1'b0;
               rdata_s = bus.s_rdata;
            end else if (timeout_hit_s) begin
               done_s  = 1'b1;
               err_s   = 1'b1;
               rdata_s = {DATA_WIDTH{1'b0}};
            end else begin
               done_s  = 1'b0;
               err_s   = 1'b0;
               rdata_s = {DATA_WIDTH{1'b0}};
            end

            if (done_s) begin
               state_d = IDLE;
               last_d  = (state_q == GNT1);
               cnt_d   = {CW{1'b0}};
            end else begin
               cnt_d   = cnt_q + CW'(1'b1);
            end

            if (state_q == GNT0) begin
               bus.m0_ack   = done_s;
               bus.m0_err   = err_s;
               bus.m0_rdata = rdata_s;
            end else begin
               bus.m1_ack   = done_s;
               bus.m1_err   = err_s;
               bus.m1_rdata = rdata_s;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {CW{1'b0}};
         end
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (TIMEOUT_CYCLES = 4).
module tb_bus_arbiter;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   bus_arbiter #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.m0_req   = 1'b0;
      bus.m0_we    = 1'b0;
      bus.m0_addr  = 32'h0000_0000;
      bus.m0_wdata = 32'h0000_0000;
      bus.m1_req   = 1'b0;
      bus.m1_we    = 1'b0;
      bus.m1_addr  = 32'h0000_0000;
      bus.m1_wdata = 32'h0000_0000;
      bus.s_ack    = 1'b0;
      bus.s_rdata  = 32'h0000_0000;
   endtask

   task automatic test_reset;
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      tests_run++;
      if ({bus.s_req, bus.s_we, bus.grant, bus.busy, bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err} !== 9'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b expected 000000000",
                  {bus.s_req, bus.s_we, bus.grant, bus.busy, bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err});
      end
      tests_run++;
      if ({bus.s_addr, bus.s_wdata, bus.m0_rdata, bus.m1_rdata} !== 128'h0) begin
         tests_failed++;
         $display("FAIL reset_data: got %h expected 0", {bus.s_addr, bus.s_wdata, bus.m0_rdata, bus.m1_rdata});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_read;
      bus.m0_req  = 1'b1;
      bus.m0_we   = 1'b0;
      bus.m0_addr = 32'h0000_0100;
      #1;
      tests_run++;
      if (bus.s_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL read_latency: s_req got %b expected 0", bus.s_req);
      end
      tick();
      tests_run++;
      if ({bus.s_req, bus.grant, bus.s_addr} !== {1'b1, 2'b01, 32'h0000_0100}) begin
         tests_failed++;
         $display("FAIL read_grant: got %b %b %h expected 1 01 00000100", bus.s_req, bus.grant, bus.s_addr);
      end
      tick();
      tests_run++;
      if (bus.m0_ack !== 1'b0) begin
         tests_failed++;
         $display("FAIL read_early_ack: m0_ack got %b expected 0", bus.m0_ack);
      end
      tick();
      bus.s_ack   = 1'b1;
      bus.s_rdata = 32'hCAFE_F00D;
      #1;
      tests_run++;
      if ({bus.m0_ack, bus.m0_err, bus.m0_rdata, bus.m1_ack} !== {1'b1, 1'b0, 32'hCAFE_F00D, 1'b0}) begin
         tests_failed++;
         $display("FAIL read_ack: got ack=%b err=%b rdata=%h m1_ack=%b expected 1 0 cafef00d 0",
                  bus.m0_ack, bus.m0_err, bus.m0_rdata, bus.m1_ack);
      end
      tick();
      idle_inputs();
      #1;
      tests_run++;
      if ({bus.grant, bus.busy} !== 3'b000) begin
         tests_failed++;
         $display("FAIL read_release: grant=%b busy=%b expected 00 0", bus.grant, bus.busy);
      end
      tick();
   endtask

   task automatic test_back_to_back;
      logic [1:0] exp_grant [8];
      exp_grant = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.m0_req = 1'b1;
      bus.m1_req = 1'b1;
      bus.s_ack  = 1'b1;
      bus.s_rdata = 32'h0000_00AA;
      for (int k = 0; k < 8; k++) begin
         tick();
         tests_run++;
         if ({bus.grant, bus.m1_ack, bus.m0_ack} !== {exp_grant[k], exp_grant[k]}) begin
            tests_failed++;
            $display("FAIL rr_cycle%0d: grant=%b acks(m1,m0)=%b%b expected %b %b",
                     k, bus.grant, bus.m1_ack, bus.m0_ack, exp_grant[k], exp_grant[k]);
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_write_routing;
      bus.m1_req   = 1'b1;
      bus.m1_we    = 1'b1;
      bus.m1_addr  = 32'h0000_2000;
      bus.m1_wdata = 32'h1234_5678;
      tick();
      tests_run++;
      if ({bus.grant, bus.s_we, bus.s_addr, bus.s_wdata} !== {2'b10, 1'b1, 32'h0000_2000, 32'h1234_5678}) begin
         tests_failed++;
         $display("FAIL write_route: grant=%b we=%b addr=%h wdata=%h expected 10 1 00002000 12345678",
                  bus.grant, bus.s_we, bus.s_addr, bus.s_wdata);
      end
      tick();
      bus.s_ack = 1'b1;
      #1;
      tests_run++;
      if ({bus.m1_ack, bus.m1_err, bus.m0_ack} !== 3'b100) begin
         tests_failed++;
         $display("FAIL write_ack: m1_ack=%b m1_err=%b m0_ack=%b expected 1 0 0", bus.m1_ack, bus.m1_err, bus.m0_ack);
      end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_timeout;
      for (int pass = 0; pass < 2; pass++) begin
         bus.m0_req  = 1'b1;
         bus.m0_addr = 32'h0000_0300;
         bus.s_rdata = 32'h5555_AAAA;
         tick();
         for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (bus.m0_ack !== 1'b0) begin
               tests_failed++;
               $display("FAIL timeout_wait%0d_%0d: m0_ack got %b expected 0", pass, c, bus.m0_ack);
            end
            tick();
         end
         bus.s_ack = (pass == 1);
         #1;
         tests_run++;
         if (pass == 0) begin
            if ({bus.m0_ack, bus.m0_err, bus.m0_rdata} !== {1'b1, 1'b1, 32'h0}) begin
               tests_failed++;
               $display("FAIL timeout_err: ack=%b err=%b rdata=%h expected 1 1 00000000",
                        bus.m0_ack, bus.m0_err, bus.m0_rdata);
            end
         end else begin
            if ({bus.m0_ack, bus.m0_err, bus.m0_rdata} !== {1'b1, 1'b0, 32'h5555_AAAA}) begin
               tests_failed++;
               $display("FAIL timeout_ack_wins: ack=%b err=%b rdata=%h expected 1 0 5555aaaa",
                        bus.m0_ack, bus.m0_err, bus.m0_rdata);
            end
         end
         tick();
         idle_inputs();
         #1;
         tests_run++;
         if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_idle%0d: busy got %b expected 0", pass, bus.busy);
         end
         tick();
      end
   endtask

   task automatic test_mid_reset;
      // last owner is m0 here, so without reset a tie would go to m1
      bus.m1_req = 1'b1;
      tick();
      tests_run++;
      if (bus.grant !== 2'b10) begin
         tests_failed++;
         $display("FAIL midrst_grant: grant got %b expected 10", bus.grant);
      end
      bus.s_ack = 1'b1;
      reset     = 1'b1;
      #1;
      tests_run++;
      if ({bus.grant, bus.s_req, bus.busy, bus.m1_ack} !== 5'b00000) begin
         tests_failed++;
         $display("FAIL midrst_async: grant=%b s_req=%b busy=%b m1_ack=%b expected 00 0 0 0",
                  bus.grant, bus.s_req, bus.busy, bus.m1_ack);
      end
      tick();
      reset     = 1'b0;
      bus.s_ack = 1'b0;
      bus.m0_req = 1'b1;
      tick();
      tests_run++;
      if (bus.grant !== 2'b01) begin
         tests_failed++;
         $display("FAIL midrst_tie: grant got %b expected 01", bus.grant);
      end
      bus.s_ack = 1'b1;
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_stray_ack;
      bus.s_ack   = 1'b1;
      bus.s_rdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 2; c++) begin
         #1;
         tests_run++;
         if ({bus.m0_ack, bus.m1_ack, bus.busy, bus.grant, bus.m0_rdata} !== {5'b00000, 32'h0}) begin
            tests_failed++;
            $display("FAIL stray_ack%0d: m0_ack=%b m1_ack=%b busy=%b grant=%b m0_rdata=%h expected 0 0 0 00 0",
                     c, bus.m0_ack, bus.m1_ack, bus.busy, bus.grant, bus.m0_rdata);
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      clk          = 1'b0;
      reset        = 1'b0;
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_single_read();
      test_back_to_back();
      test_write_routing();
      test_timeout();
      test_mid_reset();
      test_stray_ack();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
